// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive path.
//   rx_state_e     - receive FSM state encoding
//   OVERSAMPLE_DEF - default baud_tick pulses per bit period
//   DATA_BITS_DEF  - default data bits per frame
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: serial input and bit-timing outputs of the RX sampler.
//   baud_tick   - 16x (OVERSAMPLE x) baud pulse, into sampler
//   rx_in       - raw asynchronous serial line, into sampler
//   bit_strobe  - one-cycle pulse per sampled data bit
//   bit_value   - sampled data bit, held between strobes
//   busy        - frame in progress
//   frame_done  - stop bit sampled high (pulse)
//   frame_error - stop bit sampled low (pulse)
// master drives the line/ticks, slave is the sampler.
interface uart_rx_sampler_if;
  logic baud_tick;
  logic rx_in;
  logic bit_strobe;
  logic bit_value;
  logic busy;
  logic frame_done;
  logic frame_error;

  modport master (
    output baud_tick, rx_in,
    input  bit_strobe, bit_value, busy, frame_done, frame_error
  );

  modport slave (
    input  baud_tick, rx_in,
    output bit_strobe, bit_value, busy, frame_done, frame_error
  );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep synchroniser for the serial line plus
// falling-edge detection on the synchronised signal.
//   i_clk  - receive clock
//   i_rst  - asynchronous active-high reset (flops reset to line-idle 1)
//   i_rx   - raw asynchronous line
//   o_rxs  - synchronised line
//   o_fall - high for one cycle when o_rxs goes 1 -> 0
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_rxs,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_d;

  // Reset to 1 so that releasing reset on an idle line is not seen as an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= '1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_rxs_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rxs  = r_sync[SYNC_STAGES-1];
  assign o_fall = r_rxs_d & ~r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: receive bit-timing front end. Detects a start edge,
// validates the start bit at its mid-point, then samples each data bit and
// the stop bit at mid-bit using the oversampling baud_tick.
//   rx_clk - receive clock
//   reset  - asynchronous active-high reset
//   bus    - uart_rx_sampler_if.slave (line/ticks in, strobes/status out)
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic              rx_clk,
  input logic              reset,
  uart_rx_sampler_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic w_rxs;
  logic w_fall;

  rx_state_e     r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          r_bit_strobe;
  logic          r_bit_value;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_frame_error;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk  (rx_clk),
    .i_rst  (reset),
    .i_rx   (bus.rx_in),
    .o_rxs  (w_rxs),
    .o_fall (w_fall)
  );

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_bit_strobe  <= 1'b0;
      r_bit_value   <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_bit_strobe  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_state)
        IDLE: begin
          // Ticks are ignored here; only a fresh falling edge starts a frame.
          if (w_fall) begin
            r_state    <= START;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b1;
          end
        end
        START: begin
          if (bus.baud_tick) begin
            if (r_tick_cnt == HALF_M1) begin
              if (w_rxs) begin
                // Line back high at mid-start: glitch, drop silently.
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state    <= DATA;
                r_tick_cnt <= '0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (bus.baud_tick) begin
            if (r_tick_cnt == FULL_M1) begin
              r_bit_strobe <= 1'b1;
              r_bit_value  <= w_rxs;
              r_bit_cnt    <= r_bit_cnt + BW'(1);
              r_tick_cnt   <= '0;
              if (r_bit_cnt == LAST_BIT) r_state <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (bus.baud_tick) begin
            if (r_tick_cnt == FULL_M1) begin
              // Leave at mid-stop so a back-to-back start edge is caught.
              r_frame_done  <= w_rxs;
              r_frame_error <= ~w_rxs;
              r_state       <= IDLE;
              r_busy        <= 1'b0;
              r_tick_cnt    <= '0;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bit_strobe  = r_bit_strobe;
  assign bus.bit_value   = r_bit_value;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_error = r_frame_error;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler. Each sent frame pushes its expected
// events (data bits LSB first, then done/error) into a queue; a negedge
// monitor pops and compares on every output pulse.
module tb_uart_rx_sampler;
  localparam int OS = 16;
  localparam int DB = 8;
  localparam int SS = 2;

  logic rx_clk = 1'b0;
  logic reset  = 1'b1;

  uart_rx_sampler_if bus_if ();

  uart_rx_sampler #(.OVERSAMPLE(OS), .DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
    .rx_clk (rx_clk),
    .reset  (reset),
    .bus    (bus_if)
  );

  always #5 rx_clk = ~rx_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tick_div = 4;
  bit busy_seen = 1'b0;
  int exp_q[$];       // 0/1 = data bit, 2 = frame_done, 3 = frame_error
  int strobe_cyc[$];

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic pop_cmp(input int act);
    int e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", act, -1);
    end else begin
      e = exp_q.pop_front();
      check("event", act, e);
    end
  endtask

  // cycle counter and watchdog
  initial forever begin
    @(posedge rx_clk);
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycle %0d, expected < 90000", cyc);
      $fatal(1, "watchdog");
    end
  end

  // baud_tick generator; tick_div == 1 holds the tick high
  initial begin
    int ph;
    ph = 0;
    bus_if.baud_tick = 1'b0;
    forever begin
      @(posedge rx_clk);
      #1;
      ph = (ph + 1 >= tick_div) ? 0 : ph + 1;
      bus_if.baud_tick = (ph == 0);
    end
  end

  // monitor
  initial forever begin
    @(negedge rx_clk);
    if (!reset) begin
      if (bus_if.busy) busy_seen = 1'b1;
      if (bus_if.frame_done && bus_if.frame_error) check("done_err_exclusive", 1, 0);
      if (bus_if.bit_strobe) begin
        strobe_cyc.push_back(cyc);
        pop_cmp(int'(bus_if.bit_value));
      end
      if (bus_if.frame_done)  pop_cmp(2);
      if (bus_if.frame_error) pop_cmp(3);
    end
  end

  // Drive the line to lvl for n baud ticks; entered and left #1 after posedge.
  task automatic hold(input logic lvl, input int n);
    int k;
    k = 0;
    bus_if.rx_in = lvl;
    while (k < n) begin
      @(posedge rx_clk);
      if (bus_if.baud_tick) k++;
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stp, input int stop_ticks);
    for (int i = 0; i < DB; i++) exp_q.push_back(int'(d[i]));
    exp_q.push_back(stp ? 2 : 3);
    hold(1'b0, OS);
    for (int i = 0; i < DB; i++) hold(d[i], OS);
    hold(stp, stop_ticks);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge rx_clk);
    while (bus_if.busy && k < 4000) begin
      @(negedge rx_clk);
      k++;
    end
    check(name, int'(bus_if.busy), 0);
    @(posedge rx_clk);
    #1;
  endtask

  initial begin
    logic [7:0] d;
    int r;
    bus_if.rx_in = 1'b1;
    repeat (3) @(posedge rx_clk);
    @(negedge rx_clk);
    check("rst_bit_strobe", int'(bus_if.bit_strobe), 0);
    check("rst_bit_value", int'(bus_if.bit_value), 0);
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_frame_done", int'(bus_if.frame_done), 0);
    check("rst_frame_error", int'(bus_if.frame_error), 0);
    @(posedge rx_clk);
    #1 reset = 1'b0;
    hold(1'b1, 4);

    // edge-to-busy latency: SYNC_STAGES+1 cycles; short pulse is a false start
    bus_if.rx_in = 1'b0;
    repeat (SS) @(posedge rx_clk);
    @(negedge rx_clk);
    check("busy_latency_early", int'(bus_if.busy), 0);
    @(posedge rx_clk);
    @(negedge rx_clk);
    check("busy_latency", int'(bus_if.busy), 1);
    @(posedge rx_clk);
    #1 bus_if.rx_in = 1'b1;
    wait_idle("false_start_idle");
    check("false_start_q", exp_q.size(), 0);

    // 0xA5 good frame
    send_frame(8'hA5, 1'b1, OS);
    wait_idle("a5_idle");
    check("a5_q", exp_q.size(), 0);

    // 4-tick glitch
    busy_seen = 1'b0;
    hold(1'b0, 4);
    hold(1'b1, 24);
    check("glitch_busy_seen", int'(busy_seen), 1);
    check("glitch_q", exp_q.size(), 0);

    // 0x3C with low stop, line held low: no restart
    send_frame(8'h3C, 1'b0, OS);
    hold(1'b0, 2 * OS);
    check("err_no_restart", int'(bus_if.busy), 0);
    hold(1'b1, OS);
    check("err_q", exp_q.size(), 0);

    // reset after 3rd strobe
    d = 8'h0F;
    for (int i = 0; i < 3; i++) exp_q.push_back(int'(d[i]));
    hold(1'b0, OS);
    for (int i = 0; i < 3; i++) hold(d[i], OS);
    reset = 1'b1;
    @(negedge rx_clk);
    check("midrst_outputs", int'({bus_if.bit_strobe, bus_if.bit_value, bus_if.busy,
                                 bus_if.frame_done, bus_if.frame_error}), 0);
    check("midrst_q", exp_q.size(), 0);
    @(posedge rx_clk);
    #1 bus_if.rx_in = 1'b1;
    @(posedge rx_clk);
    #1 reset = 1'b0;
    hold(1'b1, 8);
    send_frame(8'h5A, 1'b1, OS);
    wait_idle("5a_idle");

    // back-to-back, next start 10 ticks into stop
    strobe_cyc.delete();
    send_frame(8'h00, 1'b1, 10);
    send_frame(8'hFF, 1'b1, OS);
    wait_idle("b2b_idle");
    check("b2b_strobes", strobe_cyc.size(), 16);
    check("b2b_q", exp_q.size(), 0);

    // baud_tick held high: strobes exactly OS cycles apart
    tick_div = 1;
    hold(1'b1, 4);
    strobe_cyc.delete();
    send_frame(8'h81, 1'b1, OS);
    wait_idle("const_tick_idle");
    check("const_tick_strobes", strobe_cyc.size(), 8);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check("const_tick_spacing", strobe_cyc[i] - strobe_cyc[i-1], OS);

    // randomized frames, errors and glitches
    for (int it = 0; it < 25; it++) begin
      tick_div = $urandom_range(1, 4);
      hold(1'b1, $urandom_range(2, 6));
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r < 2) begin
        busy_seen = 1'b0;
        hold(1'b0, $urandom_range(1, 5));
        hold(1'b1, 20);
        check("rnd_glitch_busy", int'(busy_seen), 1);
      end else if (r < 4) begin
        send_frame(d, 1'b0, OS);
        hold(1'b0, $urandom_range(0, 20));
        hold(1'b1, OS);
      end else begin
        send_frame(d, 1'b1, OS);
      end
    end
    wait_idle("final_idle");
    check("final_q", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Receive-side bit-timing front end for the UART. It synchronises the asynchronous serial line, detects and validates the start bit, and samples each data bit at its mid-point using a 16x oversampling tick. For every data bit it emits a one-cycle strobe and the sampled value; the downstream serial-to-parallel deserialiser shifts on that strobe. It also checks the stop bit and reports frame completion or a framing error.

## Interface
- `OVERSAMPLE`, default 16: baud_tick pulses per bit period; even, ≥4.
- `DATA_BITS`, default 8: data bits per frame; range 5–9.
- `SYNC_STAGES`, default 2: synchroniser flops on rx_in; ≥2.

- `rx_clk` in 1: receive clock, all logic on rising edge.
- `reset` in 1: reset, asynchronous, active-high; clock rx_clk.
- `baud_tick` in 1: one-cycle pulse at OVERSAMPLE × baud rate.
- `rx_in` in 1: raw serial line, asynchronous, idle high.
- `bit_strobe` out 1: one-cycle pulse per sampled data bit.
- `bit_value` out 1: sampled data bit; valid while bit_strobe=1, holds last value otherwise.
- `busy` out 1: high from start-edge detection until return to IDLE.
- `frame_done` out 1: one-cycle pulse when the stop bit is sampled high.
- `frame_error` out 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- Synchroniser flops reset to 1. `rxs` is the synchronised line; `rxs_d` is `rxs` delayed by 1 cycle.
- Falling edge = `rxs_d`=1 and `rxs`=0. It is only acted on in IDLE.
- Counters:
  - tick_cnt: width clog2(OVERSAMPLE), advances only on baud_tick.
  - bit_cnt: width clog2(DATA_BITS+1).
- States:
  - **IDLE**: busy=0. On falling edge: go to START, tick_cnt=0, bit_cnt=0.
  - **START**: on baud_tick with tick_cnt==OVERSAMPLE/2−1, sample rxs.
    - 0: go to DATA, tick_cnt=0.
    - 1: false start; go to IDLE with no pulses.
    - Otherwise tick_cnt+1 on each baud_tick.
  - **DATA**: on baud_tick with tick_cnt==OVERSAMPLE−1: pulse bit_strobe, bit_value=rxs, bit_cnt+1, tick_cnt=0.
    - When the bit just sampled is bit DATA_BITS−1, go to STOP.
  - **STOP**: on baud_tick with tick_cnt==OVERSAMPLE−1, sample rxs.
    - 1: pulse frame_done.
    - 0: pulse frame_error.
    - Either way go to IDLE.
- Bits are delivered LSB first, in line order; no reordering here.
- After a framing error with the line held low, no new frame starts until the line returns high and falls again (edge-triggered detection).
- baud_tick in IDLE is ignored. baud_tick held high continuously is legal and counts every cycle.

## Timing
- Reset values: bit_strobe=0, bit_value=0, busy=0, frame_done=0, frame_error=0; state IDLE; counters 0.
- Reset mid-frame aborts immediately with no pulses. The next frame needs a fresh falling edge.
- Edge-to-busy latency: SYNC_STAGES+1 rx_clk cycles after rx_in falls (busy is registered).
- All outputs are registered. bit_strobe, frame_done and frame_error rise on the rx_clk edge after the sampling baud_tick cycle and last exactly 1 cycle.
- Start sample falls OVERSAMPLE/2 ticks after detection. Each data bit and the stop bit are sampled OVERSAMPLE ticks after the previous sample, i.e. at mid-bit.
- Return to IDLE happens at mid-stop-bit, so a start edge in the second half of the stop bit is accepted (back-to-back frames).
- frame_done and frame_error are mutually exclusive. busy falls in the same cycle as either pulse, or the cycle after a false-start sample.

## Structure
- Shared package `uart_pkg`:
  - state enum {IDLE, START, DATA, STOP}
  - default constants OVERSAMPLE_DEF=16, DATA_BITS_DEF=8
- One sub-module, `uart_rx_sync`: SYNC_STAGES-deep synchroniser, reset-to-1, plus the registered falling-edge detector.
- FSM and counters live in the top module.

## Test plan
- OVERSAMPLE=16, baud_tick every 4 cycles, send 0xA5 with stop=1 -> 8 bit_strobes with values 1,0,1,0,0,1,0,1, then one frame_done, no frame_error, busy=0 after.
- rx_in low for 4 baud periods' worth of ticks/16 (a 4-tick glitch) then high -> busy pulses, START sample reads 1, zero bit_strobes, no frame_done or frame_error.
- Send 0x3C with stop bit 0, then hold line low for 3 bit times -> 8 strobes 0,0,1,1,1,1,0,0, one frame_error, no restart until the line goes high then low.
- Assert reset after the 3rd bit_strobe of a frame -> all outputs 0 next cycle. The following frame 0x5A is delivered as 0,1,0,1,1,0,1,0 with frame_done.
- Back-to-back 0x00 then 0xFF, next start edge 10 ticks into the stop bit -> 16 strobes total, two frame_done pulses, no error.
- baud_tick held constantly high, send 0x81 -> strobes 1,0,0,0,0,0,0,1 spaced exactly 16 cycles apart.
